// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and types for the register-file write-back arbiter.
// Single source of the data width and register address width used by every file.
package regfile_wb_arbiter_pkg;

  localparam int DEF_WORD_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Long-latency result queue: DEPTH {addr,data} entries with per-entry valid bits and address matching.
// Pop data is visible combinationally at the head; a push is dropped when full, a pop when empty.
module regfile_wb_arbiter_wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DEPTH      = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  reg_addr_t             push_addr,
  input  logic [WORD_WIDTH-1:0] push_data,
  input  logic                  pop,
  output reg_addr_t             head_addr,
  output logic [WORD_WIDTH-1:0] head_data,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count,
  input  reg_addr_t             match_addr1,
  input  reg_addr_t             match_addr2,
  input  reg_addr_t             match_addr3,
  output logic                  match1,
  output logic                  match2,
  output logic                  match3
);

  reg_addr_t             addr_mem [DEPTH];
  logic [WORD_WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];

  // Pointers are exactly PW bits wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      valid   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        addr_mem[tail] <= push_addr;
        data_mem[tail] <= push_data;
        valid[tail]    <= 1'b1;
        tail           <= tail + PW'(1);
      end
      if (do_pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    match3 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addr_mem[i] == match_addr1)) match1 = 1'b1;
      if (valid[i] && (addr_mem[i] == match_addr2)) match2 = 1'b1;
      if (valid[i] && (addr_mem[i] == match_addr3)) match3 = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU (1 cycle) and queued long-latency results onto the single register-file write port.
// ALU always wins; memReady drops only when the queue is full; pending flags stall decode.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      aluWrite,
  input  logic [REG_ADDR_WIDTH-1:0] aluAddr,
  input  logic [WORD_WIDTH-1:0]     aluData,
  input  logic                      memValid,
  input  logic [REG_ADDR_WIDTH-1:0] memAddr,
  input  logic [WORD_WIDTH-1:0]     memData,
  output logic                      memReady,
  input  logic [REG_ADDR_WIDTH-1:0] regReadAddr1,
  input  logic [REG_ADDR_WIDTH-1:0] regReadAddr2,
  output logic                      pending1,
  output logic                      pending2,
  output logic [REG_ADDR_WIDTH-1:0] regWriteAddr,
  output logic [WORD_WIDTH-1:0]     dataToWrite,
  output logic                      toWrite,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      orderErr
);

  logic                  alu_req;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  hit1;
  logic                  hit2;
  logic                  hit_alu;
  reg_addr_t             head_addr;
  logic [WORD_WIDTH-1:0] head_data;

  // Writes to $0 are dropped at the source: an ALU request to $0 is no request at all,
  // and a long-latency handshake to $0 completes without being enqueued.
  assign alu_req  = aluWrite && (aluAddr != '0);
  assign memReady = !fifo_full;
  assign push     = memValid && memReady && (memAddr != '0);
  assign pop      = !alu_req && !fifo_empty;

  regfile_wb_arbiter_wb_fifo #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH)
  ) u_wb_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_addr   (memAddr),
    .push_data   (memData),
    .pop         (pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .count       (count),
    .match_addr1 (regReadAddr1),
    .match_addr2 (regReadAddr2),
    .match_addr3 (aluAddr),
    .match1      (hit1),
    .match2      (hit2),
    .match3      (hit_alu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toWrite      <= 1'b0;
      regWriteAddr <= '0;
      dataToWrite  <= '0;
      orderErr     <= 1'b0;
    end else begin
      if (alu_req) begin
        toWrite      <= 1'b1;
        regWriteAddr <= aluAddr;
        dataToWrite  <= aluData;
      end else if (!fifo_empty) begin
        toWrite      <= 1'b1;
        regWriteAddr <= head_addr;
        dataToWrite  <= head_data;
      end else begin
        toWrite <= 1'b0;
      end
      // An ALU write overtaking a queued write to the same register reverses WAW order.
      if (alu_req && hit_alu) orderErr <= 1'b1;
    end
  end

  assign pending1 = (regReadAddr1 != '0) &&
                    (hit1 || (toWrite && (regWriteAddr == regReadAddr1)));
  assign pending2 = (regReadAddr2 != '0) &&
                    (hit2 || (toWrite && (regWriteAddr == regReadAddr2)));

endmodule
